// File: rtl/npc_pipe_if.sv
// Bundle between D-stage control and the fetch PC unit: redirect controls in,
// fetch PC and status out.
interface npc_pipe_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic [2:0]       nextPCop;
    logic [2:0]       brType;
    logic [WIDTH-1:0] rsData;
    logic [WIDTH-1:0] rtData;
    logic [WIDTH-1:0] extendedImm;
    logic [25:0]      j_addr;
    logic [WIDTH-1:0] regPC;
    logic [WIDTH-1:0] pcD;
    logic             req;
    logic             eret;
    logic [WIDTH-1:0] epc;
    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] nextPC;
    logic             branchTaken;
    logic             pendValid;
    logic             pcAdEL;

    modport master (
        output stall, nextPCop, brType, rsData, rtData, extendedImm,
               j_addr, regPC, pcD, req, eret, epc,
        input  PC, nextPC, branchTaken, pendValid, pcAdEL
    );

    modport slave (
        input  stall, nextPCop, brType, rsData, rtData, extendedImm,
               j_addr, regPC, pcD, req, eret, epc,
        output PC, nextPC, branchTaken, pendValid, pcAdEL
    );
endinterface

// File: rtl/npc_pipe_unit.sv
// Fetch-side PC register and next-PC selection: jumps, branches, jr, stall
// hold with a one-deep pending redirect, exception entry and eret return.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// PEND_IDLE | no redirect waiting
// PEND_HELD | redirect captured during a stall, applied on release
module npc_pipe_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
    parameter logic [WIDTH-1:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [WIDTH-1:0] PC_MAX     = 32'h0000_6FFF
) (
    input logic        clk,
    input logic        reset,
    npc_pipe_if.slave  bus
);

    typedef enum logic {
        PEND_IDLE = 1'b0,
        PEND_HELD = 1'b1
    } pend_state_t;

    localparam logic [2:0] OP_JUMP   = 3'b001;
    localparam logic [2:0] OP_BRANCH = 3'b010;
    localparam logic [2:0] OP_JR     = 3'b011;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLEZ = 3'b010;
    localparam logic [2:0] BR_BGTZ = 3'b011;
    localparam logic [2:0] BR_BLTZ = 3'b100;
    localparam logic [2:0] BR_BGEZ = 3'b101;

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    pend_state_t      state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;

    // Visible copies: during reset every output reflects the reset values
    // even before the first edge has loaded them.
    logic [WIDTH-1:0] pc_vis;
    logic             pend_vis;

    logic             rs_neg, rs_zero, eq;
    logic             cond;
    logic             branch_taken;
    logic [WIDTH-1:0] j_pc, branch_pc, seq_pc;
    logic             redir_valid;
    logic [WIDTH-1:0] redir_target;

    assign pc_vis   = reset ? RESET_PC : pc_q;
    assign pend_vis = reset ? 1'b0 : (state_q == PEND_HELD);

    always_comb begin
        rs_neg  = bus.rsData[WIDTH-1];
        rs_zero = (bus.rsData == '0);
        eq      = (bus.rsData == bus.rtData);
        cond    = 1'b0;
        case (bus.brType)
            BR_BEQ:  cond = eq;
            BR_BNE:  cond = !eq;
            BR_BLEZ: cond = rs_neg || rs_zero;
            BR_BGTZ: cond = !rs_neg && !rs_zero;
            BR_BLTZ: cond = rs_neg;
            BR_BGEZ: cond = !rs_neg;
            default: cond = 1'b0;
        endcase
        branch_taken = (bus.nextPCop == OP_BRANCH) && cond;
    end

    assign j_pc      = {bus.pcD[WIDTH-1:28], bus.j_addr, 2'b00};
    assign branch_pc = bus.pcD + PC_STEP + {bus.extendedImm[WIDTH-3:0], 2'b00};
    assign seq_pc    = pc_vis + PC_STEP;

    always_comb begin
        redir_valid  = 1'b0;
        redir_target = branch_pc;
        case (bus.nextPCop)
            OP_JUMP: begin
                redir_valid  = 1'b1;
                redir_target = j_pc;
            end
            OP_JR: begin
                redir_valid  = 1'b1;
                redir_target = bus.regPC;
            end
            OP_BRANCH: begin
                redir_valid  = branch_taken;
                redir_target = branch_pc;
            end
            default: begin
                redir_valid  = 1'b0;
                redir_target = branch_pc;
            end
        endcase
    end

    // Next-PC priority: reset, req, eret, stall, fresh redirect, pending, seq.
    always_comb begin
        state_d       = state_q;
        pend_target_d = pend_target_q;
        pc_d          = seq_pc;
        if (reset) begin
            state_d       = PEND_IDLE;
            pend_target_d = '0;
            pc_d          = RESET_PC;
        end else if (bus.req) begin
            state_d = PEND_IDLE;
            pc_d    = HANDLER_PC;
        end else if (bus.eret && !bus.stall) begin
            state_d = PEND_IDLE;
            pc_d    = bus.epc;
        end else if (bus.stall) begin
            pc_d = pc_q;
            if (redir_valid) begin
                state_d       = PEND_HELD;
                pend_target_d = redir_target;
            end
        end else if (redir_valid) begin
            state_d = PEND_IDLE;
            pc_d    = redir_target;
        end else if (state_q == PEND_HELD) begin
            state_d = PEND_IDLE;
            pc_d    = pend_target_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= PEND_IDLE;
            pc_q          <= RESET_PC;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign bus.PC          = pc_vis;
    assign bus.nextPC      = pc_d;
    assign bus.branchTaken = branch_taken;
    assign bus.pendValid   = pend_vis;
    assign bus.pcAdEL      = (pc_vis[1:0] != 2'b00) || (pc_vis < RESET_PC) ||
                             (pc_vis > PC_MAX);

endmodule

// File: tb/tb_npc_pipe_unit.sv
// Directed and randomized check of npc_pipe_unit against a cycle-level
// reference model of the PC selection rules.
module tb_npc_pipe_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] HND_PC = 32'h0000_4180;
    localparam logic [31:0] MAX_PC = 32'h0000_6FFF;

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    npc_pipe_if #(.WIDTH(32)) bus ();

    npc_pipe_unit #(
        .WIDTH(32), .RESET_PC(RST_PC), .HANDLER_PC(HND_PC), .PC_MAX(MAX_PC)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [31:0] m_pc;
    logic        m_pv;
    logic [31:0] m_pt;
    logic [31:0] n_pc;
    logic        n_pv;
    logic [31:0] n_pt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_taken();
        logic [31:0] rs;
        logic        neg, zero;
        rs   = bus.rsData;
        neg  = rs[31];
        zero = (rs == 0);
        if (bus.nextPCop != 3'd2) return 1'b0;
        case (bus.brType)
            3'd0: return rs == bus.rtData;
            3'd1: return rs != bus.rtData;
            3'd2: return neg || zero;
            3'd3: return !neg && !zero;
            3'd4: return neg;
            3'd5: return !neg;
            default: return 1'b0;
        endcase
    endfunction

    // Compares every output against the model at mid-cycle, then advances
    // the model across the rising edge.
    task automatic tick();
        logic        taken, redir;
        logic [31:0] tgt, vis_pc;
        logic        vis_pv, adel;
        @(negedge clk);
        taken  = ref_taken();
        redir  = 1'b0;
        tgt    = 32'h0;
        if (bus.nextPCop == 3'd1) begin
            redir = 1'b1;
            tgt   = {bus.pcD[31:28], bus.j_addr, 2'b00};
        end else if (bus.nextPCop == 3'd3) begin
            redir = 1'b1;
            tgt   = bus.regPC;
        end else if (taken) begin
            redir = 1'b1;
            tgt   = bus.pcD + 32'd4 + bus.extendedImm * 32'd4;
        end
        vis_pc = reset ? RST_PC : m_pc;
        vis_pv = reset ? 1'b0 : m_pv;
        n_pc = vis_pc + 32'd4;
        n_pv = m_pv;
        n_pt = m_pt;
        if (reset) begin
            n_pc = RST_PC; n_pv = 1'b0; n_pt = 32'h0;
        end else if (bus.req) begin
            n_pc = HND_PC; n_pv = 1'b0;
        end else if (bus.eret && !bus.stall) begin
            n_pc = bus.epc; n_pv = 1'b0;
        end else if (bus.stall) begin
            n_pc = m_pc;
            if (redir) begin
                n_pv = 1'b1; n_pt = tgt;
            end
        end else if (redir) begin
            n_pc = tgt; n_pv = 1'b0;
        end else if (m_pv) begin
            n_pc = m_pt; n_pv = 1'b0;
        end
        adel = (vis_pc % 4 != 0) || (vis_pc < RST_PC) || (vis_pc > MAX_PC);
        chk("PC", bus.PC, vis_pc);
        chk("nextPC", bus.nextPC, n_pc);
        chk("branchTaken", {31'b0, bus.branchTaken}, {31'b0, taken});
        chk("pendValid", {31'b0, bus.pendValid}, {31'b0, vis_pv});
        chk("pcAdEL", {31'b0, bus.pcAdEL}, {31'b0, adel});
        @(posedge clk);
        #1;
        m_pc = n_pc;
        m_pv = n_pv;
        m_pt = n_pt;
    endtask

    task automatic idle_inputs();
        bus.stall = 0; bus.nextPCop = 3'd0; bus.brType = 3'd0;
        bus.rsData = 0; bus.rtData = 0; bus.extendedImm = 0; bus.j_addr = 0;
        bus.regPC = 0; bus.pcD = 32'h0000_3010; bus.req = 0; bus.eret = 0;
        bus.epc = 0;
    endtask

    initial begin
        m_pc = 32'hxxxx_xxxx; m_pv = 1'b0; m_pt = 32'h0;
        reset = 1'b1;
        idle_inputs();
        #1;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_pc", bus.PC, 32'h0000_3000);

        // idle sequencing
        tick(); tick(); tick();
        chk("idle_pc", bus.PC, 32'h0000_300C);
        chk("idle_adel", {31'b0, bus.pcAdEL}, 32'h0);

        // bne not taken, then taken back to 0x300C
        bus.pcD = 32'h0000_3010; bus.nextPCop = 3'd2; bus.brType = 3'd1;
        bus.rsData = 5; bus.rtData = 5; bus.extendedImm = 32'hFFFF_FFFE;
        tick();
        chk("bne_nt_pc", bus.PC, 32'h0000_3010);
        bus.rtData = 6;
        tick();
        chk("bne_t_pc", bus.PC, 32'h0000_300C);

        // condition sweep; stalled so the sweep does not move PC
        bus.stall = 1; bus.extendedImm = 0; bus.rtData = 0;
        bus.rsData = 32'h8000_0000;
        for (int b = 2; b < 8; b++) begin
            bus.brType = 3'(b);
            #1;
            chk("sweep_neg", {31'b0, bus.branchTaken},
                {31'b0, (b == 2 || b == 4) ? 1'b1 : 1'b0});
            tick();
        end
        bus.rsData = 0;
        for (int b = 2; b < 8; b++) begin
            bus.brType = 3'(b);
            #1;
            chk("sweep_zero", {31'b0, bus.branchTaken},
                {31'b0, (b == 2 || b == 5) ? 1'b1 : 1'b0});
            tick();
        end
        bus.stall = 0; bus.nextPCop = 3'd0;
        tick();
        bus.nextPCop = 3'd3; bus.regPC = 32'h0000_3020;
        tick();
        bus.nextPCop = 3'd0;

        // jump captured during a 3-cycle stall
        bus.stall = 1; bus.nextPCop = 3'd1; bus.j_addr = 26'h0000C10;
        tick();
        bus.nextPCop = 3'd0;
        tick(); tick();
        chk("stall_hold_pc", bus.PC, 32'h0000_3020);
        chk("stall_pend", {31'b0, bus.pendValid}, 32'h1);
        bus.stall = 0;
        tick();
        chk("pend_release_pc", bus.PC, 32'h0000_3040);
        chk("pend_cleared", {31'b0, bus.pendValid}, 32'h0);

        // fresh jr beats stale pending target
        bus.stall = 1; bus.nextPCop = 3'd1;
        tick();
        bus.stall = 0; bus.nextPCop = 3'd3; bus.regPC = 32'h0000_3100;
        tick();
        chk("jr_over_pend_pc", bus.PC, 32'h0000_3100);
        chk("jr_over_pend_pv", {31'b0, bus.pendValid}, 32'h0);
        bus.nextPCop = 3'd0;
        tick();
        chk("after_jr_seq", bus.PC, 32'h0000_3104);

        // req under stall, misaligned jr, eret return
        bus.stall = 1; bus.req = 1;
        tick();
        chk("req_pc", bus.PC, 32'h0000_4180);
        bus.stall = 0; bus.req = 0; bus.nextPCop = 3'd3; bus.regPC = 32'h0000_3002;
        tick();
        chk("adel_flag", {31'b0, bus.pcAdEL}, 32'h1);
        bus.nextPCop = 3'd0; bus.eret = 1; bus.epc = 32'h0000_3008;
        tick();
        chk("eret_pc", bus.PC, 32'h0000_3008);
        bus.eret = 0;
        tick();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset           = ($urandom_range(0, 99) < 2);
            bus.stall       = ($urandom_range(0, 99) < 30);
            bus.req         = ($urandom_range(0, 99) < 4);
            bus.eret        = ($urandom_range(0, 99) < 8);
            bus.nextPCop    = 3'($urandom_range(0, 7));
            bus.brType      = 3'($urandom_range(0, 7));
            bus.rsData      = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            bus.rtData      = ($urandom_range(0, 2) == 0) ? bus.rsData : $urandom;
            bus.extendedImm = {{16{1'b0}}, 16'($urandom)};
            if (bus.extendedImm[15]) bus.extendedImm[31:16] = 16'hFFFF;
            bus.j_addr      = 26'($urandom);
            bus.regPC       = 32'h0000_3000 + 32'($urandom_range(0, 16383));
            bus.pcD         = $urandom;
            bus.epc         = 32'h0000_3000 + 32'($urandom_range(0, 4095) * 4);
            tick();
        end
        reset = 0;
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/npc_pipe_unit.md
Name: npc_pipe_unit

Overview:
- Fetch-side PC unit for the pipelined CPU: holds the F-stage PC register and computes next-PC from D-stage control (jump, jr, six branch conditions).
- Supports stall hold and redirects that arrive during a stall.
- Supports exception entry and eret return.
- Flags illegal fetch addresses (AdEL) for the exception logic.

Parameters:
- WIDTH, 32, PC/data width; must be >= 32.
- RESET_PC, 32'h00003000, PC value after reset.
- HANDLER_PC, 32'h00004180, exception handler entry address.
- PC_MAX, 32'h00006FFF, highest legal fetch byte address.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- stall  in  1  hazard stall; PC holds while 1
- nextPCop  in  3  000 seq, 001 j/jal, 010 branch, 011 jr/jalr, others seq
- brType  in  3  000 beq, 001 bne, 010 blez, 011 bgtz, 100 bltz, 101 bgez, others never taken
- rsData  in  WIDTH  forwarded rs value (D stage)
- rtData  in  WIDTH  forwarded rt value (D stage)
- extendedImm  in  WIDTH  sign-extended 16-bit offset
- j_addr  in  26  jump index field
- regPC  in  WIDTH  jr target (forwarded rs)
- pcD  in  WIDTH  PC of the instruction in D
- req  in  1  exception/interrupt request
- eret  in  1  eret in D
- epc  in  WIDTH  return address for eret
- PC  out  WIDTH  current fetch PC (registered)
- nextPC  out  WIDTH  value PC loads at next edge (combinational)
- branchTaken  out  1  branch condition true this cycle (nextPCop==010 only)
- pendValid  out  1  latched redirect waiting for stall release
- pcAdEL  out  1  PC misaligned or outside [RESET_PC, PC_MAX]

Behaviour:
- Reset: PC=RESET_PC, pendValid=0, pendTarget=0. While reset is high, every output is derived from these values.
- Condition evaluation:
  - eq = rsData==rtData.
  - Signed compares on rsData against zero: lez (rs<=0), gtz (rs>0), ltz (rs<0), gez (rs>=0).
  - branchTaken = (nextPCop==010) & cond(brType).
- Targets:
  - jPC = {pcD[WIDTH-1:28], j_addr, 2'b00}.
  - branchPC = pcD + 4 + (extendedImm<<2), truncated to WIDTH (wraps modulo 2^WIDTH).
  - seqPC = PC + 4, truncated to WIDTH.
- redirValid = (op==001) | (op==011) | branchTaken. redirTarget is jPC, regPC or branchPC respectively.
- A non-taken branch is not a redirect.
- Next-PC priority, highest first; all effects apply at the next rising clk edge:
  1. reset
  2. req: nextPC=HANDLER_PC; pending cleared; overrides stall.
  3. eret (stall=0): nextPC=epc; pending cleared.
  4. stall=1: PC holds. If redirValid, pendTarget<=redirTarget and pendValid<=1; a later redirect during the same stall overwrites it.
  5. redirValid (stall=0): nextPC=redirTarget; pending cleared. A fresh redirect wins over a stale pending one.
  6. pendValid (stall=0): nextPC=pendTarget; pendValid<=0.
  7. Otherwise nextPC=seqPC.
- eret with stall=1 is ignored; D re-presents it after the stall.
- The nextPC output is the value PC will take at the next edge. Under stall it equals PC.
- pcAdEL = (PC[1:0]!=0) | (PC<RESET_PC) | (PC>PC_MAX), unsigned compares, combinational from the registered PC.
- pcAdEL does not alter PC flow; the exception logic answers it with req.
- Single-cycle latency from control inputs to PC. No bubbles are inserted internally.
- Reset mid-stall or with pending set: pending is discarded and PC=RESET_PC next cycle.

Test Plan:
- Reset, then 3 idle cycles, op=000 -> PC 00003000, 00003004, 00003008, 0000300C; pcAdEL=0.
- pcD=00003010, op=010, brType=001, rs=5, rt=5, imm=FFFFFFFE -> not taken, PC=PC+4. Then rs=5, rt=6 -> taken, PC=0000300C.
- brType sweep with rs=80000000 (negative): bltz and blez taken; bgez and bgtz not taken. rs=0: blez and bgez taken only.
- stall=1 for 3 cycles with op=001, j_addr=0000C10 in cycle 1 -> PC frozen, pendValid=1, pendTarget=00003040. After release, PC=00003040 and pendValid=0.
- Pending set, then stall=0 with op=011, regPC=00003100 -> PC=00003100; pending cleared.
- stall=1 with req=1 -> PC=00004180 next cycle. Then op=011, regPC=00003002 -> pcAdEL=1. Then eret with epc=00003008 -> PC=00003008.
